// File: rtl/wb_pkg.sv
// Shared types and widths for the register write-back stage.
// Entries carry the destination, the value and whether it came from a load.
package wb_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int NREGS     = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic                 is_load;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of write-back entries.
// The entry array, valid mask and head pointer are exposed for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push0,
  input  wb_entry_t             din0,
  input  logic                  push1,
  input  wb_entry_t             din1,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [PW:0]           count,
  output wb_entry_t [DEPTH-1:0] ents,
  output logic [DEPTH-1:0]      valid,
  output logic [PW-1:0]         rd_ptr
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [PW-1:0]         off;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push0) begin
      mem_d[wr_ptr_q] = din0;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    // push1 is younger; it lands after push0 when both fire
    if (push1) begin
      mem_d[wr_ptr_d] = din1;
      wr_ptr_d = wr_ptr_d + PW'(1);
    end
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q
             + (PW+1)'(push0)
             + (PW+1)'(push1)
             - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    valid = '0;
    off   = '0;
    for (int s = 0; s < DEPTH; s++) begin
      off      = PW'(s) - rd_ptr_q;
      valid[s] = {1'b0, off} < count_q;
    end
  end

  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign ents   = mem_q;
  assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: merges ALU and load results, drains one rf write per cycle,
// tracks outstanding loads and forwards buffered values to decode.
module reg_writeback
  import wb_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [REG_IDX_W-1:0] ld_issue_rd,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 mem_ready,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [NREGS-1:0]     busy,
  input  logic [REG_IDX_W-1:0] q_rs,
  output logic                 q_hit,
  output logic [XLEN-1:0]      q_data
);

  wb_entry_t                  head, mem_e, alu_e;
  wb_entry_t [FIFO_DEPTH-1:0] ents;
  logic [FIFO_DEPTH-1:0]      valid;
  logic [PW-1:0]              rd_ptr;
  logic [PW:0]                count;
  logic                       mem_en, alu_en, pop;
  logic                       push0, push1;
  wb_entry_t                  din0;

  logic                 rf_we_q, rf_we_d;
  logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]     busy_q, busy_d;

  // Drain is not credited, so two accepts never overflow the buffer
  assign mem_ready = count < (PW+1)'(FIFO_DEPTH);
  assign alu_ready = (count + (PW+1)'(mem_valid & mem_ready))
                   < (PW+1)'(FIFO_DEPTH);

  assign mem_en = mem_valid & mem_ready & (mem_rd != '0);
  assign alu_en = alu_valid & alu_ready & (alu_rd != '0);
  assign pop    = count != '0;

  assign mem_e = '{rd: mem_rd, data: mem_data, is_load: 1'b1};
  assign alu_e = '{rd: alu_rd, data: alu_data, is_load: 1'b0};

  assign push0 = mem_en | alu_en;
  assign din0  = mem_en ? mem_e : alu_e;
  assign push1 = mem_en & alu_en;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push0  (push0),
    .din0   (din0),
    .push1  (push1),
    .din1   (alu_e),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .ents   (ents),
    .valid  (valid),
    .rd_ptr (rd_ptr)
  );

  always_comb begin
    rf_we_d    = pop;
    rf_rd_d    = pop ? head.rd   : rf_rd_q;
    rf_wdata_d = pop ? head.data : rf_wdata_q;
    busy_d     = busy_q;
    if (pop && head.is_load) busy_d[head.rd] = 1'b0;
    if (ld_issue) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match is the youngest
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && q_rs != '0 && ents[idx].rd == q_rs) begin
        q_hit  = 1'b1;
        q_data = ents[idx].data;
      end
    end
  end

endmodule
